// File: rtl/hazard_controller.sv
// hazard_controller: RV32I 5-stage pipeline sequencer for load-use stalls, redirect flushes and memory waits
// Ports: clk/reset_n (sync active-low); id_rs1/id_rs2 (ID sources); id_ex_rd/id_ex_MemRead (EX load);
//        ex_redirect (taken branch/jump); mem_req/mem_ready (data memory handshake);
//        pc_write, if_id_write/flush, id_ex_write/flush, ex_mem_write, mem_wb_flush (stage controls);
//        stall_cycles/flush_events (saturating performance counters)
module hazard_controller #(
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_MemRead,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;
  state_t state_q, state_d, sv_q, sv_d, es;
  logic [2:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic mem_wait, load_use, fl, st;
  assign mem_wait = mem_req && !mem_ready;
  assign load_use = id_ex_MemRead && id_ex_rd != 5'd0 && (id_ex_rd == id_rs1 || id_ex_rd == id_rs2);
  // While frozen, the interrupted sequence lives in sv_q and cnt_q is simply held,
  // so the cycle that releases the wait runs as the saved state.
  assign es = state_q == MEM_WAIT ? sv_q : state_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      sv_q    <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = RUN;
    sv_d    = sv_q;
    cnt_d   = 3'd0;
    if (mem_wait) begin
      state_d = MEM_WAIT;
      sv_d    = es;
      cnt_d   = cnt_q;
    end else if (ex_redirect) begin
      state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_d   = 3'(FLUSH_CYCLES - 1);
    end else if (es != RUN) begin
      state_d = cnt_q == 3'd1 ? RUN : es;
      cnt_d   = cnt_q - 3'd1;
    end else if (load_use) begin
      state_d = LOAD_USE_STALL > 1 ? LU_STALL : RUN;
      cnt_d   = 3'(LOAD_USE_STALL - 1);
    end
  end
  // Mealy outputs: flush wins over stall, memory wait freezes everything.
  assign fl = !mem_wait && (ex_redirect || es == FLUSH);
  assign st = !mem_wait && !fl && (es == LU_STALL || (es == RUN && load_use));
  always_comb begin
    pc_write     = reset_n && !mem_wait && !st;
    if_id_write  = reset_n && !mem_wait && !st;
    if_id_flush  = !reset_n || fl;
    id_ex_write  = reset_n && !mem_wait;
    id_ex_flush  = !reset_n || fl || st;
    ex_mem_write = reset_n && !mem_wait;
    mem_wb_flush = !reset_n || mem_wait;
  end
  always_comb begin
    stall_d = (!pc_write && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (ex_redirect && !mem_wait && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
endmodule
